// File: rtl/eth_tx_framer_pkg.sv
// Shared constants, state encoding and counter widths for the GMII transmit framer.
package eth_tx_framer_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    localparam int unsigned MIN_LEN_DEF = 60;
    localparam int unsigned MAX_LEN_DEF = 1514;
    localparam int unsigned IFG_LEN_DEF = 12;
    localparam int unsigned PRE_LEN_DEF = 7;

    localparam int unsigned BCNT_W = 11;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_ABORT,
        ST_DROP
    } tx_state_e;

endpackage

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero pad, FCS from an external CRC32 engine, IFG.
// GMII outputs are registered; CRC strobes and s_ready follow the registered state in the same cycle.
module eth_tx_framer
    import eth_tx_framer_pkg::*;
#(
    parameter int unsigned MIN_LEN = MIN_LEN_DEF,
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned IFG_LEN = IFG_LEN_DEF,
    parameter int unsigned PRE_LEN = PRE_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        crc_init,
    output logic        crc_upd,
    output logic [7:0]  crc_data,
    input  logic [31:0] crc_val,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy
);

    localparam logic [CNT_W-1:0]  PRE_LOAD  = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0]  IFG_LOAD  = CNT_W'(IFG_LEN - 1);
    localparam logic [CNT_W-1:0]  FCS_LOAD  = CNT_W'(3);
    localparam logic [BCNT_W-1:0] MIN_CNT   = BCNT_W'(MIN_LEN);
    localparam logic [BCNT_W-1:0] MAX_CNT   = BCNT_W'(MAX_LEN);

    tx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [BCNT_W-1:0]  byte_inc;
    logic [23:0]        fcs_q, fcs_d;
    logic               last_seen_q, last_seen_d;
    logic [7:0]         txd_q, txd_d;
    logic               en_q, en_d;
    logic               er_q, er_d;
    logic               busy_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        byte_cnt_d  = byte_cnt_q;
        fcs_d       = fcs_q;
        last_seen_d = last_seen_q;
        txd_d       = 8'h00;
        en_d        = 1'b0;
        er_d        = 1'b0;
        s_ready     = 1'b0;
        crc_init    = 1'b0;
        crc_upd     = 1'b0;
        crc_data    = 8'h00;
        byte_inc    = byte_cnt_q + BCNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    state_d = ST_PRE;
                    cnt_d   = PRE_LOAD;
                end
            end
            ST_PRE: begin
                txd_d = PREAMBLE_BYTE;
                en_d  = 1'b1;
                if (cnt_q == '0) state_d = ST_SFD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_SFD: begin
                txd_d       = SFD_BYTE;
                en_d        = 1'b1;
                crc_init    = 1'b1;
                byte_cnt_d  = '0;
                last_seen_d = 1'b0;
                state_d     = ST_DATA;
            end
            ST_DATA: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    txd_d      = s_data;
                    en_d       = 1'b1;
                    crc_upd    = 1'b1;
                    crc_data   = s_data;
                    byte_cnt_d = byte_inc;
                    if (s_last) begin
                        last_seen_d = 1'b1;
                        if (byte_inc < MIN_CNT) begin
                            state_d = ST_PAD;
                        end else begin
                            state_d = ST_FCS;
                            cnt_d   = FCS_LOAD;
                        end
                    end else if (byte_inc == MAX_CNT) begin
                        state_d = ST_ABORT;
                    end
                end else begin
                    state_d = ST_ABORT;
                end
            end
            ST_PAD: begin
                en_d       = 1'b1;
                crc_upd    = 1'b1;
                byte_cnt_d = byte_inc;
                if (byte_inc == MIN_CNT) begin
                    state_d = ST_FCS;
                    cnt_d   = FCS_LOAD;
                end
            end
            ST_FCS: begin
                en_d = 1'b1;
                // crc_val settles on the first FCS cycle; byte 0 goes straight out, the rest are held
                if (cnt_q == FCS_LOAD) begin
                    txd_d = crc_val[7:0];
                    fcs_d = crc_val[31:8];
                end else begin
                    txd_d = fcs_q[7:0];
                    fcs_d = {8'h00, fcs_q[23:8]};
                end
                if (cnt_q == '0) begin
                    state_d = ST_IFG;
                    cnt_d   = IFG_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_IFG: begin
                // a waiting frame starts directly so back-to-back gaps are exactly IFG_LEN
                if (cnt_q == '0) begin
                    if (s_valid) begin
                        state_d = ST_PRE;
                        cnt_d   = PRE_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ABORT: begin
                en_d = 1'b1;
                er_d = 1'b1;
                if (last_seen_q) begin
                    state_d = ST_IFG;
                    cnt_d   = IFG_LOAD;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    state_d = ST_IFG;
                    cnt_d   = IFG_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            byte_cnt_q  <= '0;
            fcs_q       <= '0;
            last_seen_q <= 1'b0;
            txd_q       <= 8'h00;
            en_q        <= 1'b0;
            er_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            fcs_q       <= fcs_d;
            last_seen_q <= last_seen_d;
            txd_q       <= txd_d;
            en_q        <= en_d;
            er_q        <= er_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign gmii_txd   = txd_q;
    assign gmii_tx_en = en_q;
    assign gmii_tx_er = er_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Framer paired with a byte-wide CRC32 engine; frame vectors from a table plus back-to-back and reset sequences.
module tb_eth_tx_framer;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        crc_init;
    logic        crc_upd;
    logic [7:0]  crc_data;
    logic [31:0] crc_val;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;

    eth_tx_framer dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .crc_init   (crc_init),
        .crc_upd    (crc_upd),
        .crc_data   (crc_data),
        .crc_val    (crc_val),
        .gmii_txd   (gmii_txd),
        .gmii_tx_en (gmii_tx_en),
        .gmii_tx_er (gmii_tx_er),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    logic [31:0] eng_q = 32'hFFFFFFFF;
    always @(posedge clk) begin
        if (crc_init)     eng_q <= 32'hFFFFFFFF;
        else if (crc_upd) eng_q <= crc_step(eng_q, crc_data);
    end
    assign crc_val = ~eng_q;

    function automatic logic [31:0] crc32_model(input logic [7:0] d[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (d[k]) c = crc_step(c, d[k]);
        return ~c;
    endfunction

    function automatic logic [7:0] pat(input int i, input int seed);
        return 8'(i + 17 * seed);
    endfunction

    // monitor: samples 1 ns after the falling edge
    logic [7:0] wire_q[$];
    logic [7:0] crcb_q[$];
    int en_cnt = 0, er_cnt = 0, upd_cnt = 0, init_cnt = 0, rdy_cnt = 0;
    int last_en_cyc = 0, last_xfer_cyc = 0, busy_fall_cyc = 0, gap_last = 0;
    bit prev_en = 0, prev_busy = 0, seen_en = 0;

    always begin
        @(negedge clk);
        #1;
        if (gmii_tx_en) begin
            if (!prev_en && seen_en) gap_last = cyc - last_en_cyc - 1;
            wire_q.push_back(gmii_txd);
            en_cnt++;
            last_en_cyc = cyc;
            seen_en = 1;
        end
        if (gmii_tx_er) er_cnt++;
        if (crc_upd) begin
            upd_cnt++;
            crcb_q.push_back(crc_data);
        end
        if (crc_init) init_cnt++;
        if (s_ready) rdy_cnt++;
        if (s_valid && s_ready) last_xfer_cyc = cyc;
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_en   = gmii_tx_en;
        prev_busy = busy;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int len;
        int stall_at;
        int exp_en;
        int exp_er;
        int exp_upd;
        int exp_ready;
        int exp_tail;
        bit good;
    } vec_t;

    vec_t vecs[9];

    logic [7:0] exp_w[$];
    logic [7:0] exp_c[$];

    task automatic append_expect(input int len, input int stall_at, input int seed);
        logic [7:0] fr[$];
        logic [31:0] fcs;
        int nd;
        bit abort;
        nd = len;
        abort = 0;
        if (stall_at >= 0 && stall_at < len) begin
            nd = stall_at;
            abort = 1;
        end else if (len > 1514) begin
            nd = 1514;
            abort = 1;
        end
        repeat (7) exp_w.push_back(8'h55);
        exp_w.push_back(8'hD5);
        for (int i = 0; i < nd; i++) fr.push_back(pat(i, seed));
        if (!abort) while (fr.size() < 60) fr.push_back(8'h00);
        foreach (fr[k]) begin
            exp_w.push_back(fr[k]);
            exp_c.push_back(fr[k]);
        end
        if (abort) begin
            exp_w.push_back(8'h00);
        end else begin
            fcs = crc32_model(fr);
            exp_w.push_back(fcs[7:0]);
            exp_w.push_back(fcs[15:8]);
            exp_w.push_back(fcs[23:16]);
            exp_w.push_back(fcs[31:24]);
        end
    endtask

    task automatic compare_streams(input string tag, input int w0, input int c0);
        int bad_w, bad_c;
        bad_w = 0;
        bad_c = 0;
        foreach (exp_w[k]) if (w0 + k >= wire_q.size() || wire_q[w0 + k] !== exp_w[k]) bad_w++;
        foreach (exp_c[k]) if (c0 + k >= crcb_q.size() || crcb_q[c0 + k] !== exp_c[k]) bad_c++;
        chk({tag, " wire bytes wrong"}, 32'(bad_w), 32'd0);
        chk({tag, " crc bytes wrong"}, 32'(bad_c), 32'd0);
    endtask

    task automatic send_frame(input int len, input int stall_at, input int stall_n,
                              input int seed, input bit keep);
        int i, st, guard;
        i = 0;
        st = 0;
        guard = 0;
        while (i < len && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (i == stall_at && st < stall_n) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                st++;
            end else begin
                s_valid = 1'b1;
                s_data  = pat(i, seed);
                s_last  = (i == len - 1);
                if (s_ready) i++;
            end
        end
        if (i < len) chk("drive timeout", 32'(i), 32'(len));
        if (!keep) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            #2;
            g++;
        end while (busy && g < 5000);
        if (busy) chk("idle timeout", 32'd1, 32'd0);
    endtask

    task automatic run_vec(input int v);
        int en0, er0, upd0, init0, rdy0, w0, c0, tail, n;
        logic [31:0] fcs_act, fcs_exp;
        string t;
        t = $sformatf("v%0d", v);
        en0 = en_cnt; er0 = er_cnt; upd0 = upd_cnt; init0 = init_cnt; rdy0 = rdy_cnt;
        w0 = wire_q.size();
        c0 = crcb_q.size();
        send_frame(vecs[v].len, vecs[v].stall_at, 3, v, 1'b0);
        wait_idle();
        chk({t, " tx_en cycles"}, 32'(en_cnt - en0), 32'(vecs[v].exp_en));
        chk({t, " tx_er cycles"}, 32'(er_cnt - er0), 32'(vecs[v].exp_er));
        chk({t, " crc_upd cycles"}, 32'(upd_cnt - upd0), 32'(vecs[v].exp_upd));
        chk({t, " crc_init pulses"}, 32'(init_cnt - init0), 32'd1);
        chk({t, " s_ready cycles"}, 32'(rdy_cnt - rdy0), 32'(vecs[v].exp_ready));
        tail = vecs[v].good ? (busy_fall_cyc - last_en_cyc) : (busy_fall_cyc - last_xfer_cyc);
        chk({t, " ifg tail"}, 32'(tail), 32'(vecs[v].exp_tail));
        exp_w.delete();
        exp_c.delete();
        append_expect(vecs[v].len, vecs[v].stall_at, v);
        compare_streams(t, w0, c0);
        if (vecs[v].good) begin
            n = wire_q.size();
            fcs_act = (n >= 4) ? {wire_q[n-1], wire_q[n-2], wire_q[n-3], wire_q[n-4]} : 32'h0;
            fcs_exp = crc32_model(exp_c);
            chk({t, " fcs"}, fcs_act, fcs_exp);
        end
    endtask

    function automatic logic [31:0] out_bits();
        return 32'({s_ready, crc_init, crc_upd, crc_data, gmii_txd, gmii_tx_en, gmii_tx_er, busy});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0, er0, rdy0, init0, w0, c0, i, g;

        //          len  stall  en    er upd   ready tail good
        vecs[0] = '{60,   -1,   72,   0, 60,   60,   12, 1};
        vecs[1] = '{14,   -1,   72,   0, 60,   14,   12, 1};
        vecs[2] = '{59,   -1,   72,   0, 60,   59,   12, 1};
        vecs[3] = '{1,    -1,   72,   0, 60,   1,    12, 1};
        vecs[4] = '{61,   -1,   73,   0, 61,   61,   12, 1};
        vecs[5] = '{1514, -1,   1526, 0, 1514, 1514, 12, 1};
        vecs[6] = '{25,   20,   29,   1, 20,   27,   13, 0};
        vecs[7] = '{1515, -1,   1523, 1, 1514, 1515, 13, 0};
        vecs[8] = '{64,   -1,   76,   0, 64,   64,   12, 1};

        rst = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = 8'h00;
        repeat (4) @(negedge clk);
        #2;
        chk("reset outputs", out_bits(), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 9; v++) run_vec(v);

        // back-to-back frames with s_valid held high throughout
        en0 = en_cnt; er0 = er_cnt; rdy0 = rdy_cnt; init0 = init_cnt;
        w0 = wire_q.size();
        c0 = crcb_q.size();
        send_frame(64, -1, 0, 20, 1'b1);
        send_frame(64, -1, 0, 21, 1'b0);
        wait_idle();
        chk("b2b gap", 32'(gap_last), 32'd12);
        chk("b2b tx_en cycles", 32'(en_cnt - en0), 32'd152);
        chk("b2b tx_er cycles", 32'(er_cnt - er0), 32'd0);
        chk("b2b s_ready cycles", 32'(rdy_cnt - rdy0), 32'd128);
        chk("b2b crc_init pulses", 32'(init_cnt - init0), 32'd2);
        exp_w.delete();
        exp_c.delete();
        append_expect(64, -1, 20);
        append_expect(64, -1, 21);
        compare_streams("b2b", w0, c0);

        // reset in the middle of payload, then a clean frame
        i = 0;
        g = 0;
        while (i < 10 && g < 200) begin
            @(negedge clk);
            g++;
            s_valid = 1'b1;
            s_last  = 1'b0;
            s_data  = pat(i, 30);
            if (s_ready) i++;
        end
        chk("rst pre-frame progress", 32'(i), 32'd10);
        @(negedge clk);
        chk("rst pre tx_en", 32'(gmii_tx_en), 32'd1);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("rst mid-frame outputs", out_bits(), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
